// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Opcodes, one-hot op codes, ID_EX layout and decode helper
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam logic [5:0] OPC_ADD  = 6'd0;
    localparam logic [5:0] OPC_SUB  = 6'd1;
    localparam logic [5:0] OPC_LDI  = 6'd2;
    localparam logic [5:0] OPC_SHL  = 6'd3;
    localparam logic [5:0] OPC_SHR  = 6'd4;
    localparam logic [5:0] OPC_AND  = 6'd5;
    localparam logic [5:0] OPC_OR   = 6'd6;
    localparam logic [5:0] OPC_XOR  = 6'd7;
    localparam logic [5:0] OPC_BR   = 6'd8;
    localparam logic [5:0] OPC_BNE  = 6'd9;
    localparam logic [5:0] OPC_MOVE = 6'd10;
    localparam logic [5:0] OPC_ADDI = 6'd11;
    localparam logic [5:0] OPC_MULT = 6'd12;
    localparam logic [5:0] OPC_HALT = 6'd13;
    localparam logic [5:0] OPC_NOP  = 6'd14;

    localparam logic [15:0] OP_ADD  = 16'h0001;
    localparam logic [15:0] OP_SUB  = 16'h0002;
    localparam logic [15:0] OP_LDI  = 16'h0004;
    localparam logic [15:0] OP_SHL  = 16'h0008;
    localparam logic [15:0] OP_SHR  = 16'h0010;
    localparam logic [15:0] OP_AND  = 16'h0020;
    localparam logic [15:0] OP_OR   = 16'h0040;
    localparam logic [15:0] OP_XOR  = 16'h0080;
    localparam logic [15:0] OP_BR   = 16'h0100;
    localparam logic [15:0] OP_BNE  = 16'h0200;
    localparam logic [15:0] OP_MOVE = 16'h0400;
    localparam logic [15:0] OP_ADDI = 16'h0800;
    localparam logic [15:0] OP_MULT = 16'h1000;
    localparam logic [15:0] OP_HALT = 16'h2000;
    localparam logic [15:0] OP_NOP  = 16'h4000;

    // Operation classes as masks over the one-hot op code
    localparam logic [15:0] DEST_RD_MASK = OP_ADD | OP_SUB | OP_SHL | OP_SHR | OP_AND
                                         | OP_OR | OP_XOR | OP_MOVE | OP_MULT;
    localparam logic [15:0] DEST_RT_MASK = OP_LDI | OP_ADDI;
    localparam logic [15:0] WRITER_MASK  = DEST_RD_MASK | DEST_RT_MASK;
    localparam logic [15:0] RS_MASK      = OP_ADD | OP_SUB | OP_AND | OP_OR | OP_XOR
                                         | OP_MULT | OP_BNE | OP_SHL | OP_SHR;
    localparam logic [15:0] RT_MASK      = OP_ADD | OP_SUB | OP_AND | OP_OR | OP_XOR
                                         | OP_MULT | OP_BNE | OP_MOVE | OP_ADDI;

    localparam int IDEX_W         = 161;
    localparam int IDEX_PC_LSB    = 0;
    localparam int IDEX_RS_LSB    = 32;
    localparam int IDEX_RT_LSB    = 64;
    localparam int IDEX_DEST_LSB  = 96;
    localparam int IDEX_ZERO_LSB  = 101;
    localparam int IDEX_OP_LSB    = 112;
    localparam int IDEX_IMM_LSB   = 128;
    localparam int IDEX_IMM2_LSB  = 144;
    localparam int IDEX_VALID_BIT = 160;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_HALTED = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic [15:0] op;
        logic [4:0]  dest;
        logic        writer;
        logic        use_rs;
        logic        use_rt;
        logic        is_halt;
    } dec_t;

    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] opc;
        opc       = instr[31:26];
        d.op      = (opc < OPC_NOP) ? (16'h0001 << opc) : OP_NOP;
        if ((d.op & DEST_RD_MASK) != 16'h0000) begin
            d.dest = instr[15:11];
        end else if ((d.op & DEST_RT_MASK) != 16'h0000) begin
            d.dest = instr[20:16];
        end else begin
            d.dest = 5'd0;
        end
        d.writer  = ((d.op & WRITER_MASK) != 16'h0000) && (d.dest != 5'd0);
        d.use_rs  = (d.op & RS_MASK) != 16'h0000;
        d.use_rt  = (d.op & RT_MASK) != 16'h0000;
        d.is_halt = (d.op == OP_HALT);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : Register file, two async reads with write-through, r0 == 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [NREGS-1:0][DW-1:0] r_mem;
    logic                     w_wr_live;

    // Entry 0 is never written, so it stays at its reset value of zero
    assign w_wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (w_wr_live) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (w_wr_live && (wr_addr == rd_addr_a)) ? wr_data : r_mem[rd_addr_a];
    assign rd_data_b = (w_wr_live && (wr_addr == rd_addr_b)) ? wr_data : r_mem[rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode with RAW stall, flush and HALT latch
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import pipe_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int PEND_W = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     if_valid,
    input  logic [31:0]              if_instr,
    input  logic [31:0]              if_pc,
    output logic                     id_ready,
    input  logic                     wb_we,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     ex_flush,
    output logic [IDEX_W-1:0]        ID_EX,
    output logic                     halted
);

    localparam int AW       = $clog2(NREGS);
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    dec_state_t                   r_state;
    dec_state_t                   w_state_nxt;
    logic [IDEX_W-1:0]            r_idex;
    logic [IDEX_W-1:0]            w_idex_nxt;
    logic [NREGS-1:0][PEND_W-1:0] r_pend;
    logic [NREGS-1:0][PEND_W-1:0] w_pend_nxt;
    int                           w_net;

    dec_t        w_dec;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_haz_rs;
    logic        w_haz_rt;
    logic        w_haz_wr;
    logic        w_hazard;
    logic        w_accept;
    logic        w_idex_valid;
    logic [4:0]  w_idex_dest;

    assign w_dec = decode_instr(if_instr);
    assign w_rs  = if_instr[25:21];
    assign w_rt  = if_instr[20:16];

    reg_file #(
        .NREGS (NREGS),
        .DW    (32)
    ) u_reg_file (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_addr_a (w_rs),
        .rd_addr_b (w_rt),
        .rd_data_a (w_rs_val),
        .rd_data_b (w_rt_val),
        .wr_en     (wb_we),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // r0 never carries a pending count, so only non-zero sources can stall
    assign w_haz_rs = w_dec.use_rs && (w_rs != '0) && (r_pend[w_rs] != '0);
    assign w_haz_rt = w_dec.use_rt && (w_rt != '0) && (r_pend[w_rt] != '0);
    assign w_haz_wr = w_dec.writer && (r_pend[w_dec.dest] == PEND_W'(PEND_MAX));
    assign w_hazard = w_haz_rs || w_haz_rt || w_haz_wr;

    assign id_ready = (r_state != ST_HALTED) && !w_hazard && !ex_flush;
    assign w_accept = if_valid && id_ready;

    assign w_idex_valid = r_idex[IDEX_VALID_BIT];
    assign w_idex_dest  = r_idex[IDEX_DEST_LSB +: 5];

    assign w_idex_nxt = {1'b1, if_instr[15:0], if_instr[15:0], w_dec.op, 11'd0,
                         w_dec.dest, w_rt_val, w_rs_val, if_pc};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idex <= '0;
        end else if (w_accept) begin
            r_idex <= w_idex_nxt;
        end else begin
            r_idex[IDEX_VALID_BIT] <= 1'b0;
        end
    end

    // Net issue, writeback and squash per register, clamped to the counter range
    always_comb begin
        w_pend_nxt = r_pend;
        w_net      = 0;
        for (int i = 1; i < NREGS; i++) begin
            w_net = int'(r_pend[i])
                  + int'(w_accept && w_dec.writer && (w_dec.dest == 5'(i)))
                  - int'(wb_we && (wb_addr == AW'(i)))
                  - int'(ex_flush && w_idex_valid && (w_idex_dest == 5'(i)));
            if (w_net < 0) begin
                w_net = 0;
            end else if (w_net > PEND_MAX) begin
                w_net = PEND_MAX;
            end
            w_pend_nxt[i] = w_net[PEND_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_dec.is_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (if_valid && w_hazard) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (w_accept && w_dec.is_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (!w_hazard) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign ID_EX  = r_idex;
    assign halted = (r_state == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed and randomized checks of decode_stage vs a model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    logic         clock;
    logic         reset_n;
    logic         if_valid;
    logic [31:0]  if_instr;
    logic [31:0]  if_pc;
    logic         id_ready;
    logic         wb_we;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic         ex_flush;
    logic [160:0] ID_EX;
    logic         halted;

    int n_run;
    int n_fail;

    decode_stage #(.NREGS(32), .PEND_W(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .id_ready (id_ready),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ex_flush (ex_flush),
        .ID_EX    (ID_EX),
        .halted   (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [31:0]  m_regs [32];
    int           m_pend [32];
    bit           m_halted;
    logic [160:0] m_idex;

    function automatic int f_idx(input logic [31:0] ins);
        int o;
        o = int'(ins[31:26]);
        return (o > 14) ? 14 : o;
    endfunction

    function automatic logic [4:0] f_dest(input logic [31:0] ins);
        case (f_idx(ins))
            0, 1, 3, 4, 5, 6, 7, 10, 12: return ins[15:11];
            2, 11:                       return ins[20:16];
            default:                     return 5'd0;
        endcase
    endfunction

    function automatic bit f_writer(input logic [31:0] ins);
        return (f_idx(ins) inside {0, 1, 2, 3, 4, 5, 6, 7, 10, 11, 12}) && (f_dest(ins) != 5'd0);
    endfunction

    function automatic bit f_rs_src(input logic [31:0] ins);
        return f_idx(ins) inside {0, 1, 3, 4, 5, 6, 7, 9, 12};
    endfunction

    function automatic bit f_rt_src(input logic [31:0] ins);
        return f_idx(ins) inside {0, 1, 5, 6, 7, 9, 10, 11, 12};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_ready();
        logic [4:0] rs;
        logic [4:0] rt;
        rs = if_instr[25:21];
        rt = if_instr[20:16];
        if (m_halted || ex_flush) return 1'b0;
        if (f_rs_src(if_instr) && rs != 5'd0 && m_pend[rs] != 0) return 1'b0;
        if (f_rt_src(if_instr) && rt != 5'd0 && m_pend[rt] != 0) return 1'b0;
        if (f_writer(if_instr) && m_pend[f_dest(if_instr)] >= 3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mk(input int opc, input int rs, input int rt, input int rd, input int low);
        return {6'(opc), 5'(rs), 5'(rt), 5'(rd), 11'(low)};
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit we, input int wa,
                         input logic [31:0] wd, input bit fl);
        if_valid = v;
        if_instr = ins;
        if_pc    = $urandom;
        wb_we    = we;
        wb_addr  = 5'(wa);
        wb_data  = wd;
        ex_flush = fl;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge
    task automatic tick();
        bit           acc;
        logic [160:0] nidex;
        logic [15:0]  oh;
        int           npend [32];
        bit           we;
        logic [4:0]   wa;
        logic [31:0]  wd;
        acc   = if_valid && m_ready();
        nidex = m_idex;
        nidex[160] = 1'b0;
        oh    = 16'h0001 << f_idx(if_instr);
        if (acc)
            nidex = {1'b1, if_instr[15:0], if_instr[15:0], oh, 11'd0, f_dest(if_instr),
                     m_read(if_instr[20:16]), m_read(if_instr[25:21]), if_pc};
        npend[0] = 0;
        for (int r = 1; r < 32; r++) begin
            int d;
            d = m_pend[r];
            if (acc && f_writer(if_instr) && f_dest(if_instr) == 5'(r)) d++;
            if (wb_we && wb_addr == 5'(r)) d--;
            if (ex_flush && m_idex[160] && m_idex[100:96] == 5'(r)) d--;
            npend[r] = (d < 0) ? 0 : ((d > 3) ? 3 : d);
        end
        we = wb_we; wa = wb_addr; wd = wb_data;
        if (acc && f_idx(if_instr) == 13) m_halted = 1'b1;
        @(posedge clock);
        m_idex = nidex;
        m_pend = npend;
        if (we && wa != 5'd0) m_regs[wa] = wd;
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive(0, 32'd0, 0, 0, 32'd0, 0);
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_pend[r] = 0;
        end
        m_idex   = '0;
        m_halted = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, mk(0, 1, 2, 3, 0), 0, 0, 32'd0, 0);
        n_run++;
        if (ID_EX !== 161'd0) begin n_fail++; $display("FAIL reset_idex got=%h exp=0", ID_EX); end
        n_run++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
        apply_reset();
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", id_ready); end
    endtask

    task automatic test_add();
        apply_reset();
        drive(0, 32'd0, 1, 1, 32'd5, 0);
        tick();
        drive(1, mk(0, 1, 2, 3, 0), 1, 2, 32'd7, 0);
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready got=%b exp=1", id_ready); end
        tick();
        n_run++;
        if (ID_EX[127:112] !== 16'h0001) begin n_fail++; $display("FAIL add_op got=%h exp=0001", ID_EX[127:112]); end
        n_run++;
        if (ID_EX[63:32] !== 32'd5 || ID_EX[95:64] !== 32'd7) begin
            n_fail++; $display("FAIL add_operands got=%0d,%0d exp=5,7", ID_EX[63:32], ID_EX[95:64]);
        end
        n_run++;
        if (ID_EX[100:96] !== 5'd3 || ID_EX[160] !== 1'b1) begin
            n_fail++; $display("FAIL add_dest_valid got=%0d,%b exp=3,1", ID_EX[100:96], ID_EX[160]);
        end
        n_run++;
        if (ID_EX !== m_idex) begin n_fail++; $display("FAIL add_bus got=%h exp=%h", ID_EX, m_idex); end
    endtask

    // Follows test_add: r3 is still pending
    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            drive(1, mk(1, 3, 1, 4, 0), 0, 0, 32'd0, 0);
            n_run++;
            if (id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got=%b exp=0", id_ready); end
            tick();
            n_run++;
            if (ID_EX[160] !== 1'b0) begin n_fail++; $display("FAIL raw_bubble got=%b exp=0", ID_EX[160]); end
        end
        drive(1, mk(1, 3, 1, 4, 0), 1, 3, 32'd12, 0);
        n_run++;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle got=%b exp=0", id_ready); end
        tick();
        drive(1, mk(1, 3, 1, 4, 0), 0, 0, 32'd0, 0);
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got=%b exp=1", id_ready); end
        tick();
        n_run++;
        if (ID_EX[63:32] !== 32'd12 || ID_EX[127:112] !== 16'h0002 || ID_EX[160] !== 1'b1) begin
            n_fail++; $display("FAIL raw_sub got=rs%0d op%h v%b exp=rs12 op0002 v1", ID_EX[63:32], ID_EX[127:112], ID_EX[160]);
        end
        n_run++;
        if (ID_EX !== m_idex) begin n_fail++; $display("FAIL raw_bus got=%h exp=%h", ID_EX, m_idex); end
    endtask

    task automatic test_pend_sat();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, mk(2, 0, 5, 0, k + 1), 0, 0, 32'd0, 0);
            n_run++;
            if (id_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue%0d got=%b exp=1", k, id_ready); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, mk(2, 0, 5, 0, 9), 0, 0, 32'd0, 0);
            n_run++;
            if (id_ready !== 1'b0) begin n_fail++; $display("FAIL sat_fourth got=%b exp=0", id_ready); end
            tick();
        end
        drive(1, mk(2, 0, 5, 0, 9), 1, 5, 32'd77, 0);
        n_run++;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL sat_wb_cycle got=%b exp=0", id_ready); end
        tick();
        drive(1, mk(2, 0, 5, 0, 9), 0, 0, 32'd0, 0);
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL sat_release got=%b exp=1", id_ready); end
        tick();
        n_run++;
        if (ID_EX[160] !== 1'b1 || ID_EX[100:96] !== 5'd5) begin
            n_fail++; $display("FAIL sat_bus got=v%b d%0d exp=v1 d5", ID_EX[160], ID_EX[100:96]);
        end
        drive(1, mk(2, 0, 5, 0, 10), 0, 0, 32'd0, 0);
        n_run++;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL sat_again got=%b exp=0", id_ready); end
        reset_n = 1'b0;
        #1;
        n_run++;
        if (ID_EX !== 161'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL sat_reset got=%h exp=0", ID_EX); end
        apply_reset();
        drive(1, mk(2, 0, 5, 0, 10), 0, 0, 32'd0, 0);
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL sat_cleared got=%b exp=1", id_ready); end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1, mk(2, 0, 6, 0, 16'h1234), 0, 0, 32'd0, 0);
        tick();
        drive(1, mk(10, 0, 6, 7, 0), 0, 0, 32'd0, 1);
        n_run++;
        if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
        tick();
        n_run++;
        if (ID_EX[160] !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", ID_EX[160]); end
        drive(1, mk(10, 0, 6, 7, 0), 0, 0, 32'd0, 0);
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_reader got=%b exp=1", id_ready); end
        tick();
        n_run++;
        if (ID_EX !== m_idex || ID_EX[160] !== 1'b1) begin n_fail++; $display("FAIL flush_bus got=%h exp=%h", ID_EX, m_idex); end
    endtask

    task automatic test_nop40();
        apply_reset();
        drive(1, mk(40, 9, 9, 9, 16'h055), 0, 0, 32'd0, 0);
        tick();
        n_run++;
        if (ID_EX[127:112] !== 16'h4000 || ID_EX[100:96] !== 5'd0) begin
            n_fail++; $display("FAIL nop40 got=op%h d%0d exp=op4000 d0", ID_EX[127:112], ID_EX[100:96]);
        end
        drive(1, mk(0, 9, 9, 10, 0), 0, 0, 32'd0, 0);
        n_run++;
        if (id_ready !== 1'b1) begin n_fail++; $display("FAIL nop40_nopend got=%b exp=1", id_ready); end
        tick();
    endtask

    task automatic test_halt();
        apply_reset();
        drive(1, mk(13, 1, 2, 3, 0), 0, 0, 32'd0, 0);
        tick();
        n_run++;
        if (halted !== 1'b1 || ID_EX[127:112] !== 16'h2000 || ID_EX[160] !== 1'b1) begin
            n_fail++; $display("FAIL halt_issue got=h%b op%h v%b exp=h1 op2000 v1", halted, ID_EX[127:112], ID_EX[160]);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, mk(0, 1, 2, 3, 0), 0, 0, 32'd0, 0);
            n_run++;
            if (id_ready !== 1'b0) begin n_fail++; $display("FAIL halt_ready got=%b exp=0", id_ready); end
            tick();
            n_run++;
            if (ID_EX[160] !== 1'b0 || halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_hold got=v%b h%b exp=v0 h1", ID_EX[160], halted);
            end
        end
        reset_n = 1'b0;
        #1;
        n_run++;
        if (ID_EX !== 161'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset got=%h h%b exp=0 h0", ID_EX, halted);
        end
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            int opc;
            opc = $urandom_range(0, 63);
            if (opc == 13) opc = 14;
            drive($urandom_range(0, 3) != 0,
                  mk(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom, $urandom_range(0, 9) == 0);
            n_run++;
            if (id_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, id_ready, m_ready()); end
            tick();
            n_run++;
            if (ID_EX !== m_idex) begin n_fail++; $display("FAIL rnd_bus c=%0d got=%h exp=%h", c, ID_EX, m_idex); end
            n_run++;
            if (halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, halted, m_halted); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        n_run   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_pend_sat();
        test_flush();
        test_nop40();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
